// File: rtl/control_rd_sequencer.sv
// rtl/control_rd_sequencer.sv - read-stage sequencer for the dual-mode DNN datapath control blocks
// Steps rd_stage through one stage sequence per row, then drains the pipeline before signalling done.
module control_rd_sequencer #(
    parameter int STAGE_W     = 4,
    parameter int ROW_W       = 8,
    parameter int LAST_STG_M0 = 11,
    parameter int LAST_STG_M1 = 7,
    parameter int DRAIN_CYC   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode_in,
    input  logic [ROW_W-1:0]   num_rows,
    input  logic               stall,
    output logic [STAGE_W-1:0] rd_stage,
    output logic               stage_vld,
    output logic [ROW_W-1:0]   row_cnt,
    output logic               last_row,
    output logic               sshr_sel,
    output logic               busy,
    output logic               done
);

    localparam int DRN_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_FIN
    } state_t;

    state_t             state;
    logic               mode_q;
    logic [ROW_W-1:0]   rows_q;
    logic [DRN_W-1:0]   drain_cnt;
    logic [STAGE_W-1:0] last_stg;

    always_comb begin
        last_stg = mode_q ? STAGE_W'(LAST_STG_M1) : STAGE_W'(LAST_STG_M0);
    end

    // stage_vld must drop in the same cycle stall rises, so it is decoded rather than registered
    assign stage_vld = (state == S_RUN) && !stall;
    assign last_row  = (state == S_RUN) && (row_cnt == rows_q - ROW_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            rd_stage  <= '0;
            row_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sshr_sel  <= 1'b0;
            mode_q    <= 1'b0;
            rows_q    <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        mode_q   <= mode_in;
                        rows_q   <= num_rows;
                        rd_stage <= '0;
                        row_cnt  <= '0;
                        if (num_rows == '0) begin
                            state <= S_FIN;
                            done  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (!stall) begin
                        if (rd_stage == last_stg) begin
                            if (last_row) begin
                                state     <= S_DRAIN;
                                drain_cnt <= DRN_W'(DRAIN_CYC - 1);
                            end else begin
                                rd_stage <= '0;
                                row_cnt  <= row_cnt + ROW_W'(1);
                            end
                        end else begin
                            rd_stage <= rd_stage + STAGE_W'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    // Drain runs on its own clock count; downstream stall does not extend it
                    if (drain_cnt == '0) begin
                        state    <= S_FIN;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        rd_stage <= '0;
                        row_cnt  <= '0;
                    end else begin
                        drain_cnt <= drain_cnt - DRN_W'(1);
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase

            if (state == S_IDLE || mode_q) begin
                sshr_sel <= 1'b0;
            end else if (rd_stage == STAGE_W'(7) || rd_stage == STAGE_W'(10)) begin
                sshr_sel <= 1'b1;
            end else if (rd_stage == STAGE_W'(6) || rd_stage == STAGE_W'(9)) begin
                sshr_sel <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_control_rd_sequencer.sv
// tb/tb_control_rd_sequencer.sv - self-checking bench for control_rd_sequencer
// Job-level model: progress is a count of consumed stages, outputs derived by division/modulo.
module tb_control_rd_sequencer;

    localparam int DRAIN = 2;

    logic       clk = 1'b0;
    logic       rst, start, mode_in, stall;
    logic [7:0] num_rows;
    logic [3:0] rd_stage;
    logic [7:0] row_cnt;
    logic       stage_vld, last_row, sshr_sel, busy, done;

    control_rd_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mode_in   (mode_in),
        .num_rows  (num_rows),
        .stall     (stall),
        .rd_stage  (rd_stage),
        .stage_vld (stage_vld),
        .row_cnt   (row_cnt),
        .last_row  (last_row),
        .sshr_sel  (sshr_sel),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int nchk = 0, nerr = 0, cyc = 0;
    // phase: 0 idle, 1 run, 2 drain, 3 fin
    int m_phase = 0, m_k = 0, m_total = 0, m_drain = 0, m_mode = 0, m_rows = 0, m_sshr = 0;
    int start_cyc = 0, lat = 0, vld_cnt = 0;
    bit seen_done = 0;

    function automatic int mlast();
        return (m_mode != 0) ? 7 : 11;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic compare();
        int L, e_rd, e_row, active;
        L      = mlast();
        active = (m_phase == 1 || m_phase == 2) ? 1 : 0;
        e_rd   = active ? m_k % (L + 1) : 0;
        e_row  = active ? m_k / (L + 1) : 0;
        chk("rd_stage",  int'(rd_stage),  e_rd);
        chk("row_cnt",   int'(row_cnt),   e_row);
        chk("stage_vld", int'(stage_vld), (m_phase == 1 && !stall) ? 1 : 0);
        chk("last_row",  int'(last_row),  (m_phase == 1 && e_row == m_rows - 1) ? 1 : 0);
        chk("busy",      int'(busy),      active);
        chk("done",      int'(done),      (m_phase == 3) ? 1 : 0);
        chk("sshr_sel",  int'(sshr_sel),  m_sshr);
    endtask

    task automatic model_step(input bit r, input bit s, input bit md, input int nr, input bit sl);
        int L, rd_pre;
        if (r) begin
            m_phase = 0; m_k = 0; m_total = 0; m_drain = 0;
            m_mode = 0; m_rows = 0; m_sshr = 0;
        end else begin
            L      = mlast();
            rd_pre = (m_phase == 1 || m_phase == 2) ? m_k % (L + 1) : 0;
            if (m_phase == 0 || m_mode != 0) m_sshr = 0;
            else if (rd_pre == 7 || rd_pre == 10) m_sshr = 1;
            else if (rd_pre == 6 || rd_pre == 9) m_sshr = 0;
            case (m_phase)
                0: if (s) begin
                    m_mode = md;
                    m_rows = nr;
                    m_k    = 0;
                    if (nr == 0) m_phase = 3;
                    else begin
                        m_phase = 1;
                        m_total = nr * (mlast() + 1);
                    end
                end
                1: if (!sl) begin
                    if (m_k == m_total - 1) begin
                        m_phase = 2;
                        m_drain = DRAIN;
                    end else m_k++;
                end
                2: begin
                    m_drain--;
                    if (m_drain == 0) m_phase = 3;
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    task automatic tick(input bit r, input bit s, input bit md, input int nr, input bit sl);
        rst = r; start = s; mode_in = md; num_rows = nr[7:0]; stall = sl;
        #1;
        compare();
        if (stage_vld) vld_cnt++;
        if (done && !seen_done) begin
            seen_done = 1;
            lat = cyc - start_cyc;
        end
        if (s && !r && m_phase == 0) start_cyc = cyc;
        @(posedge clk);
        #1;
        model_step(r, s, md, nr, sl);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_job(input bit md, input int nr, input int stall_stage, input int stall_len,
                           input int mid_start_at, input int budget, input int exp_lat,
                           input int exp_vld, input string tag);
        int stalled = 0, n = 0;
        bit sl;
        seen_done = 0;
        vld_cnt   = 0;
        tick(0, 1, md, nr, 0);
        while (!seen_done && n < budget) begin
            sl = (m_phase == 1 && (m_k % (mlast() + 1)) == stall_stage && stalled < stall_len);
            if (sl) stalled++;
            tick(0, n == mid_start_at, ~md, 5, sl);
            n++;
        end
        if (!seen_done) chk({tag, "_done_timeout"}, 0, 1);
        else begin
            chk({tag, "_latency"}, lat, exp_lat);
            chk({tag, "_vld_count"}, vld_cnt, exp_vld);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1; start = 0; mode_in = 0; num_rows = 0; stall = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        tick(0, 0, 0, 0, 0);
        run_job(0, 2, -1, 0, -1, 100, 27, 24, "m0_rows2");
        run_job(1, 3, -1, 0, -1, 100, 27, 24, "m1_rows3");
        run_job(0, 1, 5, 3, -1, 100, 18, 12, "m0_stall");
        run_job(0, 0, -1, 0, -1, 20, 1, 0, "zero_rows");
        run_job(0, 2, -1, 0, 10, 100, 27, 24, "ignored_start");
        run_job(0, 1, -1, 0, -1, 100, 15, 12, "start_after_done");

        seen_done = 0;
        tick(0, 1, 0, 2, 0);
        n = 0;
        while (!(m_phase == 1 && m_k == 16) && n < 50) begin
            tick(0, 0, 0, 0, 0);
            n++;
        end
        chk("reach_row1_stage4", int'(rd_stage) + 16 * int'(row_cnt), 4 + 16 * 1);
        tick(1, 0, 0, 0, 0);
        repeat (5) tick(0, 0, 0, 0, 0);
        chk("no_done_after_rst", int'(seen_done), 0);
        run_job(1, 1, -1, 0, -1, 50, 11, 8, "after_rst");

        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 199) == 0, $urandom_range(0, 9) == 0,
                 1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 3) == 0);
        end

        tick(1, 0, 0, 0, 0);
        run_job(1, 255, -1, 0, -1, 3000, 2043, 2040, "max_rows");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
